// File: rtl/decoder_rr_arbiter.sv
// decoder_rr_arbiter: round-robin share of a 2-to-4 enable decoder with bounded hold and a one-cycle break-before-make gap
module decoder_rr_arbiter #(
  parameter int HOLD_MAX = 4,
  parameter int CW       = $clog2(HOLD_MAX + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [1:0] sel,
  output logic       en,
  output logic [3:0] gnt,
  output logic       busy,
  output logic       timeout
);
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  state_t        r_state;
  logic [1:0]    r_ptr;
  logic [CW-1:0] r_cnt;
  logic [1:0]    w_win;
  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
    $error("HOLD_MAX must be in 1..255");
  end
  // circular scan from r_ptr; lowest offset with a request wins
  always_comb begin
    w_win = r_ptr;
    for (int k = 3; k >= 0; k--)
      if (req[r_ptr + 2'(k)]) w_win = r_ptr + 2'(k);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      sel     <= '0;
      en      <= 1'b0;
      gnt     <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      case (r_state)
        GRANT: begin
          if (!req[sel] || r_cnt == CW'(HOLD_MAX - 1)) begin
            r_state <= GAP;
            r_ptr   <= sel + 2'd1;
            timeout <= req[sel];
            en      <= 1'b0;
            gnt     <= '0;
            busy    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          timeout <= 1'b0;
          r_state <= |req ? GRANT : IDLE;
          if (|req) begin
            sel   <= w_win;
            en    <= 1'b1;
            gnt   <= 4'b0001 << w_win;
            busy  <= 1'b1;
            r_cnt <= '0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// tb_decoder_rr_arbiter: directed and random checks of two builds (HOLD_MAX=4 and 1) against a grant-level model
module tb_decoder_rr_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [1:0] sel0, sel1;
  logic       en0, en1, busy0, busy1, to0, to1;
  logic [3:0] gnt0, gnt1;
  int n_assert = 0;
  int n_fail   = 0;
  int hmax[2]    = '{4, 1};
  int m_owner[2];
  int m_held[2];
  int m_ptr[2];
  int m_sel[2];
  bit m_to[2];

  decoder_rr_arbiter #(.HOLD_MAX(4)) dut4 (
    .clk(clk), .rst(rst), .req(req), .sel(sel0), .en(en0),
    .gnt(gnt0), .busy(busy0), .timeout(to0));
  decoder_rr_arbiter #(.HOLD_MAX(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .sel(sel1), .en(en1),
    .gnt(gnt1), .busy(busy1), .timeout(to1));

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1;
      m_held[d]  = 0;
      m_ptr[d]   = 0;
      m_sel[d]   = 0;
      m_to[d]    = 1'b0;
    end
  endtask

  // a grant lasts until its request drops or it has been held hmax cycles;
  // the edge after a grant ends (or any idle edge) hands out the next grant
  task automatic model(input int d, input logic [3:0] r);
    if (m_owner[d] >= 0) begin
      if (!r[m_owner[d]] || m_held[d] == hmax[d]) begin
        m_to[d]    = r[m_owner[d]];
        m_ptr[d]   = (m_owner[d] + 1) % 4;
        m_owner[d] = -1;
      end else begin
        m_held[d]++;
      end
    end else begin
      m_to[d] = 1'b0;
      for (int k = 0; k < 4; k++)
        if (m_owner[d] < 0 && r[(m_ptr[d] + k) % 4]) begin
          m_owner[d] = (m_ptr[d] + k) % 4;
          m_sel[d]   = m_owner[d];
          m_held[d]  = 1;
        end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string ph);
    logic [3:0] eg0, eg1;
    eg0 = m_owner[0] >= 0 ? 4'(1 << m_owner[0]) : 4'b0000;
    eg1 = m_owner[1] >= 0 ? 4'(1 << m_owner[1]) : 4'b0000;
    chk({ph, ".h4.gnt"},  8'(gnt0),  8'(eg0));
    chk({ph, ".h4.sel"},  8'(sel0),  8'(m_sel[0]));
    chk({ph, ".h4.en"},   8'(en0),   8'(m_owner[0] >= 0));
    chk({ph, ".h4.busy"}, 8'(busy0), 8'(m_owner[0] >= 0));
    chk({ph, ".h4.to"},   8'(to0),   8'(m_to[0]));
    chk({ph, ".h1.gnt"},  8'(gnt1),  8'(eg1));
    chk({ph, ".h1.sel"},  8'(sel1),  8'(m_sel[1]));
    chk({ph, ".h1.en"},   8'(en1),   8'(m_owner[1] >= 0));
    chk({ph, ".h1.busy"}, 8'(busy1), 8'(m_owner[1] >= 0));
    chk({ph, ".h1.to"},   8'(to1),   8'(m_to[1]));
  endtask

  task automatic step(input logic [3:0] r, input string ph);
    req = r;
    @(posedge clk);
    model(0, r);
    model(1, r);
    #1;
    check_all(ph);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all("reset");
  endtask

  initial begin
    logic [3:0] r;
    model_reset();
    req = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;
    // async reset in the middle of a grant
    step(4'b0100, "pre_rst");
    step(4'b0100, "pre_rst");
    rst = 1'b1;
    #1;
    chk("async.en",   8'(en0),   8'd0);
    chk("async.gnt",  8'(gnt0),  8'd0);
    chk("async.busy", 8'(busy0), 8'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all("post_rst");
    repeat (2) step(4'b0000, "post_rst_idle");
    step(4'b1010, "first_after_rst");
    chk("first_after_rst.gnt", 8'(gnt0), 8'h02);
    do_reset();
    // single request dropped before its hold expires
    repeat (3) step(4'b0100, "single");
    chk("single.sel", 8'(sel0), 8'd2);
    step(4'b0000, "single_drop");
    chk("single_drop.to", 8'(to0), 8'd0);
    repeat (2) step(4'b0000, "single_idle");
    // everyone requesting: forced rotation with gaps
    do_reset();
    repeat (25) step(4'b1111, "all");
    // rotation with two requesters, then early drop of req[3]
    do_reset();
    repeat (7) step(4'b1010, "rot");
    chk("rot.gnt3", 8'(gnt0), 8'h08);
    step(4'b0010, "rot_drop3");
    chk("rot_drop3.to", 8'(to0), 8'd0);
    repeat (6) step(4'b0010, "rot_tail");
    // other requests ignored while requester 0 holds the grant
    do_reset();
    for (int i = 0; i < 10; i++) step({1'b0, i[0], 1'b0, 1'b1}, "ignore");
    for (int i = 0; i < 3; i++) step({1'b0, i[0], 1'b0, 1'b0}, "ignore_drop");
    step(4'b0101, "ignore_reacq");
    repeat (3) step(4'b0100, "ignore_tail");
    // single holder: HOLD_MAX=1 build alternates grant and forced gap
    do_reset();
    repeat (10) step(4'b0001, "hold1");
    // random traffic with persistent requests
    do_reset();
    r = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      step(r, "rand");
      if (i == 300) do_reset();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/decoder_rr_arbiter.md
Name: decoder_rr_arbiter

Overview:
Round-robin arbiter that shares one 2-to-4 enable decoder (sel/en → one-hot line) between four requesters.
- Drives the decoder's `sel[1:0]` and `en` inputs and provides a registered one-hot grant equal to the decoder's output.
- Enforces a bounded hold time per grant.
- Inserts a one-cycle break-before-make gap between grants, so no two decoder lines are ever active in the same or adjacent cycles.

Parameters:
- `HOLD_MAX`, default 4: maximum consecutive cycles one requester may hold a grant. Legal range is 1..255; 0 is illegal.
- `CW`, default `$clog2(HOLD_MAX+1)`: hold-counter width. Derived; not to be overridden.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req` input 4: level requests; `req[i]` high = requester i wants the resource.
- `sel` output 2: decoder select, index of current/last grantee.
- `en` output 1: decoder enable; high only while a grant is active.
- `gnt` output 4: one-hot grant, equal to `en ? (1<<sel) : 0`; registered.
- `busy` output 1: high in GRANT state.
- `timeout` output 1: one-cycle pulse when a grant is forcibly ended by `HOLD_MAX`.

Behaviour:
- Reset (async, immediate on `rst` rising):
  - Outputs: `sel`=0, `en`=0, `gnt`=0000, `busy`=0, `timeout`=0.
  - Internal: state=IDLE, priority pointer `ptr`=0, hold counter `cnt`=0.
  - Reset mid-grant drops `en`/`gnt` without waiting for a clock edge.
- States: IDLE, GRANT, GAP. All outputs are registered; no combinational path from `req` to any output.
- Winner selection (used in IDLE and GAP): the first i with `req[i]`=1 scanning circularly `ptr`, `ptr+1`, … mod 4.
- IDLE:
  - If `req`≠0 at an edge → GRANT. On that edge: `sel`=winner, `en`=1, `gnt`=1<<winner, `busy`=1, `cnt`=0.
  - Else stay in IDLE.
- GRANT (at each edge):
  - If `req[sel]`=0 → GAP, `ptr`=`sel`+1 mod 4, `timeout`=0.
  - Else if `cnt`==`HOLD_MAX`-1 → GAP, `ptr`=`sel`+1 mod 4, `timeout`=1.
  - Else `cnt`=`cnt`+1 and stay in GRANT.
  - Result: a grant lasts exactly min(request duration, `HOLD_MAX`) cycles.
  - Changes on non-granted `req` lines are ignored while in GRANT.
- GAP (exactly one cycle):
  - `en`=0, `gnt`=0, `busy`=0; `sel` holds the last grantee.
  - `timeout` is high only in a GAP entered by force, cleared at the next edge.
  - At the next edge the winner is arbitrated as in IDLE: if `req`≠0 → GRANT to the winner, else → IDLE.
- Latency and ordering:
  - Request to grant: 1 edge from IDLE.
  - Grant to grant: exactly one dead cycle.
  - A requester that was just served has lowest priority next round, including when it is forcibly timed out and still requesting.
- Wrap-around: `ptr` 3→0 and the circular scan wrap mod 4. `cnt` never exceeds `HOLD_MAX`-1.
- `HOLD_MAX`=1: every grant is one cycle followed by GAP. `timeout` pulses whenever the requester is still high at the end of its cycle.
- Invariants:
  - `gnt` is zero or one-hot.
  - `gnt`≠0 ⇔ `en`=1 ⇔ `busy`=1.

Test Plan:
1. Reset: assert `rst` mid-cycle during a GRANT → `en`=0, `gnt`=0000, `busy`=0 immediately. After release with `req`=0 → outputs stay 0 and the first grant follows `ptr`=0 order.
2. Single request, `HOLD_MAX`=4: `req`=0100 sampled at edge k, dropped before edge k+3 → `gnt`=0100, `sel`=2, `en`=1 for edges k..k+2. `gnt`=0000 with `timeout`=0 after k+3, then IDLE.
3. All requesting, `HOLD_MAX`=4: `req`=1111 held → grants 0,1,2,3,0… Each lasts 4 cycles, is separated by one GAP cycle, and `timeout`=1 in every GAP.
4. Priority rotation: from reset `req`=1010 held, `HOLD_MAX`=4 → grant 1 first (4 cycles, timeout), then 3, then 1. Dropping `req[3]` during its grant ends it early with `timeout`=0.
5. Ignore others: during a grant to 0, toggle `req[2]` every cycle → `gnt` stays 0001 until `req[0]` drops or the hold expires, then the GAP cycle, then `gnt`=0100 if `req[2]` is high at the arbitration edge.
6. `HOLD_MAX`=1 build: `req`=0001 held → `gnt` alternates 0001/0000 every cycle, with `timeout` high on each 0000 cycle.
